instruction_decode: RTL and testbench

- Decode stage directly downstream of the fetch stage.
- Consumes fetch PC/IR/NPC and the regfile read data. Drives the fetch stage's cond and pc_sel controls, the branch target (npc_ext) and the jump target (connect).
- Owns the ID/EX pipeline register, load-use and branch-operand hazard stalls, multiply/divide busy tracking, and interrupt/eret redirection.

---
 rtl/instruction_decode.sv | 345 ++++++++++++++++++++++++++++++++++
 tb/tb_instruction_decode.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode.sv
// -----------------------------------------------------------------------------
// instruction_decode
//
// Decode stage sitting directly after fetch. Decodes the fetched instruction,
// resolves branch/jump targets and the fetch-control codes, detects pipeline
// hazards (load-use, branch operand, mult/div busy), handles interrupt entry
// and eret, and owns the ID/EX pipeline register.
//
// Optional build macro: ID_STALL_CNT_EN adds the stall_cnt output, a free
// running count of clock edges on which cond was STALL.
//
// Parameters
//   MDU_CYCLES       cycles the mult/div unit stays busy after issue (1..63)
//   INTR_VECTOR_SEL  pc_sel code driven on interrupt entry
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   if_pc/if_npc     fetch PC and PC+4
//   if_ir            fetched instruction
//   rs_val/rt_val    regfile read data for IR[25:21] / IR[20:16]
//   intr_req         level interrupt request
//   cond             fetch control: 00 FLOW, 01 STALL, 10 ZERO (never driven)
//   pc_sel           0 npc_ext, 1 Rs, 2 intr, 3 EPC, 4 connect, 5 sequential
//   npc_ext          branch target
//   connect          jump target
//   epc_wr/epc_val   one-cycle EPC capture pulse and the interrupted PC
//   ex_*             ID/EX pipeline register contents
//   stall_cnt        (ID_STALL_CNT_EN only) STALL edge counter
// -----------------------------------------------------------------------------
module instruction_decode #(
    parameter int         MDU_CYCLES      = 32,
    parameter logic [2:0] INTR_VECTOR_SEL = 3'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_npc,
    input  logic [31:0] if_ir,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        intr_req,
`ifdef ID_STALL_CNT_EN
    output logic [31:0] stall_cnt,
`endif
    output logic [1:0]  cond,
    output logic [2:0]  pc_sel,
    output logic [31:0] npc_ext,
    output logic [31:0] connect,
    output logic        epc_wr,
    output logic [31:0] epc_val,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_ir,
    output logic [31:0] ex_rs_val,
    output logic [31:0] ex_rt_val,
    output logic [31:0] ex_imm32,
    output logic [4:0]  ex_dest,
    output logic        ex_mem_read,
    output logic        ex_reg_write
);

    localparam logic [1:0] COND_FLOW  = 2'b00;
    localparam logic [1:0] COND_STALL = 2'b01;

    localparam logic [2:0] PC_NPC_EXT = 3'd0;
    localparam logic [2:0] PC_RS      = 3'd1;
    localparam logic [2:0] PC_EPC     = 3'd3;
    localparam logic [2:0] PC_CONNECT = 3'd4;
    localparam logic [2:0] PC_SEQ     = 3'd5;

    localparam logic [5:0] MDU_LOAD = 6'(MDU_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HOLD2,
        ST_HOLD1,
        ST_MDU_WAIT
    } state_t;

    // -------------------------------------------------------------------------
    // Field extraction and opcode decode
    // -------------------------------------------------------------------------
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic [15:0] imm16;

    assign opcode = if_ir[31:26];
    assign funct  = if_ir[5:0];
    assign rs_idx = if_ir[25:21];
    assign rt_idx = if_ir[20:16];
    assign rd_idx = if_ir[15:11];
    assign imm16  = if_ir[15:0];

    logic is_rtype, is_beq, is_bne, is_j, is_jal, is_lw, is_sw, is_zext;
    logic is_jr, is_mult, is_div, is_mfhi, is_mflo, is_eret;

    assign is_rtype = (opcode == 6'h00);
    assign is_beq   = (opcode == 6'h04);
    assign is_bne   = (opcode == 6'h05);
    assign is_j     = (opcode == 6'h02);
    assign is_jal   = (opcode == 6'h03);
    assign is_lw    = (opcode == 6'h23);
    assign is_sw    = (opcode == 6'h2B);
    assign is_zext  = (opcode == 6'h0C) || (opcode == 6'h0D) || (opcode == 6'h0E);
    assign is_jr    = is_rtype && (funct == 6'h08);
    assign is_mult  = is_rtype && (funct == 6'h18);
    assign is_div   = is_rtype && (funct == 6'h1A);
    assign is_mfhi  = is_rtype && (funct == 6'h10);
    assign is_mflo  = is_rtype && (funct == 6'h12);
    assign is_eret  = (if_ir == 32'h4200_0018);

    logic [31:0] imm32;
    assign imm32 = is_zext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};

    // Destination register; instructions that write no GPR get 0 so that
    // ex_reg_write falls out of a simple non-zero test.
    logic [4:0] dest;
    always_comb begin
        dest = rt_idx;
        if (is_eret || is_beq || is_bne || is_j || is_sw) begin
            dest = 5'd0;
        end else if (is_jal) begin
            dest = 5'd31;
        end else if (is_rtype) begin
            dest = is_jr ? 5'd0 : rd_idx;
        end
    end

    // Source usage is conservative: an I-type that ignores rs still counts as
    // reading it, which can only add a stall, never miss one.
    logic uses_rs, uses_rt;
    assign uses_rs = is_rtype ? !(is_mfhi || is_mflo)
                              : !(is_j || is_jal || is_eret);
    assign uses_rt = (is_rtype && !(is_jr || is_mfhi || is_mflo))
                     || is_beq || is_bne || is_sw;

    // Targets wrap modulo 2^32 by construction.
    assign npc_ext = if_npc + {imm32[29:0], 2'b00};
    assign connect = {if_pc[31:28], if_ir[25:0], 2'b00};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [5:0]  mdu_cnt_q, mdu_cnt_d;
    logic        epc_wr_q;
    logic [31:0] epc_val_q;

    logic        ex_valid_q;
    logic [31:0] ex_pc_q, ex_ir_q, ex_rs_val_q, ex_rt_val_q, ex_imm32_q;
    logic [4:0]  ex_dest_q;
    logic        ex_mem_read_q, ex_reg_write_q;

    // -------------------------------------------------------------------------
    // Hazard detection against the instruction currently in EX
    // -------------------------------------------------------------------------
    logic rs_hit, rt_hit;
    logic load_use_haz, branch_haz, mdu_haz, hazard;

    assign rs_hit = (ex_dest_q != 5'd0) && (rs_idx == ex_dest_q);
    assign rt_hit = (ex_dest_q != 5'd0) && (rt_idx == ex_dest_q);

    assign load_use_haz = ex_valid_q && ex_mem_read_q &&
                          ((uses_rs && rs_hit) || (uses_rt && rt_hit));

    // Branches compare operands in this stage, so any in-flight writer of an
    // operand must retire first.
    assign branch_haz = ex_valid_q && ex_reg_write_q &&
                        (((is_beq || is_bne) && (rs_hit || rt_hit)) ||
                         (is_jr && rs_hit));

    assign mdu_haz = (is_mfhi || is_mflo || is_mult || is_div) &&
                     (mdu_cnt_q != 6'd0);

    assign hazard = load_use_haz || branch_haz || mdu_haz;

    logic br_taken;
    assign br_taken = (is_beq && (rs_val == rt_val)) ||
                      (is_bne && (rs_val != rt_val));

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    logic issue;
    logic intr_take;

    always_comb begin
        state_d   = state_q;
        cond      = COND_FLOW;
        pc_sel    = PC_SEQ;
        issue     = 1'b0;
        intr_take = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (hazard) begin
                    cond = COND_STALL;
                    // A branch waiting on a load needs the extra cycle for
                    // the load data to reach the regfile.
                    if (branch_haz && ex_mem_read_q) begin
                        state_d = ST_HOLD2;
                    end else if (mdu_haz) begin
                        state_d = ST_MDU_WAIT;
                    end else begin
                        state_d = ST_HOLD1;
                    end
                end else if (intr_req && !epc_wr_q) begin
                    // The request is masked while the EPC pulse is out so a
                    // still-asserted level request cannot re-enter before the
                    // handler has a chance to run.
                    intr_take = 1'b1;
                    pc_sel    = INTR_VECTOR_SEL;
                end else begin
                    issue = 1'b1;
                    if (is_eret) begin
                        pc_sel = PC_EPC;
                    end else if (is_jr) begin
                        pc_sel = PC_RS;
                    end else if (is_j || is_jal) begin
                        pc_sel = PC_CONNECT;
                    end else if (br_taken) begin
                        pc_sel = PC_NPC_EXT;
                    end else begin
                        pc_sel = PC_SEQ;
                    end
                end
            end

            ST_HOLD2: begin
                cond    = COND_STALL;
                state_d = ST_HOLD1;
            end

            ST_HOLD1: begin
                cond    = COND_STALL;
                state_d = ST_RUN;
            end

            ST_MDU_WAIT: begin
                cond = COND_STALL;
                // Leave once this edge drains the counter so RUN sees it at 0.
                if (mdu_cnt_q <= 6'd1) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (issue && (is_mult || is_div)) begin
            mdu_cnt_d = MDU_LOAD;
        end else if (mdu_cnt_q != 6'd0) begin
            mdu_cnt_d = mdu_cnt_q - 6'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            mdu_cnt_q <= 6'd0;
            epc_wr_q  <= 1'b0;
            epc_val_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            mdu_cnt_q <= mdu_cnt_d;
            epc_wr_q  <= intr_take;
            if (intr_take) begin
                epc_val_q <= if_pc;
            end
        end
    end

    // ID/EX: decoded instruction on issue, otherwise an all-zero bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_pc_q        <= 32'h0;
            ex_ir_q        <= 32'h0;
            ex_rs_val_q    <= 32'h0;
            ex_rt_val_q    <= 32'h0;
            ex_imm32_q     <= 32'h0;
            ex_dest_q      <= 5'd0;
            ex_mem_read_q  <= 1'b0;
            ex_reg_write_q <= 1'b0;
        end else if (issue) begin
            ex_valid_q     <= 1'b1;
            ex_pc_q        <= if_pc;
            ex_ir_q        <= if_ir;
            ex_rs_val_q    <= rs_val;
            ex_rt_val_q    <= rt_val;
            ex_imm32_q     <= imm32;
            ex_dest_q      <= dest;
            ex_mem_read_q  <= is_lw;
            ex_reg_write_q <= (dest != 5'd0);
        end else begin
            ex_valid_q     <= 1'b0;
            ex_pc_q        <= 32'h0;
            ex_ir_q        <= 32'h0;
            ex_rs_val_q    <= 32'h0;
            ex_rt_val_q    <= 32'h0;
            ex_imm32_q     <= 32'h0;
            ex_dest_q      <= 5'd0;
            ex_mem_read_q  <= 1'b0;
            ex_reg_write_q <= 1'b0;
        end
    end

`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'h0;
        end else if (cond == COND_STALL) begin
            stall_cnt_q <= stall_cnt_q + 32'h1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign epc_wr       = epc_wr_q;
    assign epc_val      = epc_val_q;
    assign ex_valid     = ex_valid_q;
    assign ex_pc        = ex_pc_q;
    assign ex_ir        = ex_ir_q;
    assign ex_rs_val    = ex_rs_val_q;
    assign ex_rt_val    = ex_rt_val_q;
    assign ex_imm32     = ex_imm32_q;
    assign ex_dest      = ex_dest_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign ex_reg_write = ex_reg_write_q;

endmodule

// File: tb/tb_instruction_decode.sv
// -----------------------------------------------------------------------------
// tb_instruction_decode
//
// Directed bench for instruction_decode (MDU_CYCLES overridden to 4). Inputs
// are driven 1 time unit after the rising edge; combinational outputs are
// checked 1 unit later and registered outputs right after the next edge.
// -----------------------------------------------------------------------------
module tb_instruction_decode;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc, if_npc, if_ir, rs_val, rt_val;
    logic        intr_req;
    logic [1:0]  cond;
    logic [2:0]  pc_sel;
    logic [31:0] npc_ext, connect, epc_val;
    logic        epc_wr;
    logic        ex_valid, ex_mem_read, ex_reg_write;
    logic [31:0] ex_pc, ex_ir, ex_rs_val, ex_rt_val, ex_imm32;
    logic [4:0]  ex_dest;
`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] LW_8     = 32'h8C28_0000; // lw   $8, 0($1)
    localparam logic [31:0] ADD_981  = 32'h0101_4820; // add  $9, $8, $1
    localparam logic [31:0] BEQ_23   = 32'h1043_FFFF; // beq  $2, $3, -1
    localparam logic [31:0] LW_2     = 32'h8C22_0000; // lw   $2, 0($1)
    localparam logic [31:0] MULT_45  = 32'h0085_0018; // mult $4, $5
    localparam logic [31:0] MFLO_6   = 32'h0000_3012; // mflo $6
    localparam logic [31:0] J_100    = 32'h0800_0100; // j    0x100
    localparam logic [31:0] ERET     = 32'h4200_0018;
    localparam logic [31:0] JAL_100  = 32'h0C00_0100; // jal  0x100
    localparam logic [31:0] JR_31    = 32'h03E0_0008; // jr   $31
    localparam logic [31:0] ORI_7    = 32'h3407_8000; // ori  $7, $0, 0x8000
    localparam logic [31:0] ADDI_7   = 32'h2007_8000; // addi $7, $0, 0x8000

    instruction_decode #(
        .MDU_CYCLES      (4),
        .INTR_VECTOR_SEL (3'd2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_pc        (if_pc),
        .if_npc       (if_npc),
        .if_ir        (if_ir),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .intr_req     (intr_req),
`ifdef ID_STALL_CNT_EN
        .stall_cnt    (stall_cnt),
`endif
        .cond         (cond),
        .pc_sel       (pc_sel),
        .npc_ext      (npc_ext),
        .connect      (connect),
        .epc_wr       (epc_wr),
        .epc_val      (epc_val),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_ir        (ex_ir),
        .ex_rs_val    (ex_rs_val),
        .ex_rt_val    (ex_rt_val),
        .ex_imm32     (ex_imm32),
        .ex_dest      (ex_dest),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; if_pc = 32'h0; if_npc = 32'h4; if_ir = NOP;
        rs_val = 32'h0; rt_val = 32'h0; intr_req = 1'b0;
        tick(); tick();
        chk("reset ex_valid", 32'(ex_valid), 32'h0);
        chk("reset ex_ir", ex_ir, 32'h0);
        chk("reset cond", 32'(cond), 32'h0);
        chk("reset pc_sel", 32'(pc_sel), 32'h5);
        chk("reset epc_wr", 32'(epc_wr), 32'h0);
        $display("txn reset: ex_valid=%0d cond=%0d pc_sel=%0d", ex_valid, cond, pc_sel);
        rst = 1'b0;

        // Load-use: lw $8 then add $9,$8,$1
        if_ir = LW_8; if_pc = 32'h1000; if_npc = 32'h1004; #1;
        chk("lw cond", 32'(cond), 32'h0);
        tick();
        chk("lw ex_dest", 32'(ex_dest), 32'h8);
        chk("lw ex_mem_read", 32'(ex_mem_read), 32'h1);
        if_ir = ADD_981; #1;
        chk("lu detect cond", 32'(cond), 32'h1);
        chk("lu detect pc_sel", 32'(pc_sel), 32'h5);
        tick();
        chk("lu bubble ex_valid", 32'(ex_valid), 32'h0);
        chk("lu bubble ex_ir", ex_ir, 32'h0);
        chk("lu hold cond", 32'(cond), 32'h1);
        tick();
        chk("lu resume cond", 32'(cond), 32'h0);
        tick();
        chk("add ex_valid", 32'(ex_valid), 32'h1);
        chk("add ex_dest", 32'(ex_dest), 32'h9);
        chk("add ex_ir", ex_ir, ADD_981);
        $display("txn load-use: add issued ex_dest=%0d", ex_dest);

        // beq not taken, then taken with backwards target
        if_ir = BEQ_23; if_npc = 32'h1004; rs_val = 32'd5; rt_val = 32'd6; #1;
        chk("beq nt pc_sel", 32'(pc_sel), 32'h5);
        rt_val = 32'd5; #1;
        chk("beq t pc_sel", 32'(pc_sel), 32'h0);
        chk("beq npc_ext", npc_ext, 32'h1000);
        chk("beq cond", 32'(cond), 32'h0);
        tick();
        chk("beq ex_reg_write", 32'(ex_reg_write), 32'h0);
        $display("txn beq: npc_ext=%08h pc_sel=0", npc_ext);

        // beq behind lw $2: detect + HOLD2 + HOLD1
        if_ir = LW_2; #1;
        tick();
        if_ir = BEQ_23; #1;
        chk("bl detect cond", 32'(cond), 32'h1);
        tick();
        chk("bl hold2 cond", 32'(cond), 32'h1);
        chk("bl hold2 ex_valid", 32'(ex_valid), 32'h0);
        tick();
        chk("bl hold1 cond", 32'(cond), 32'h1);
        tick();
        chk("bl resolve cond", 32'(cond), 32'h0);
        chk("bl resolve pc_sel", 32'(pc_sel), 32'h0);
        tick();
        $display("txn beq-after-lw: resolved");

        // Reset while in HOLD2
        if_ir = LW_2; #1;
        tick();
        if_ir = BEQ_23; #1;
        tick();
        chk("pre-rst hold2 cond", 32'(cond), 32'h1);
        rst = 1'b1; if_ir = NOP; #1;
        chk("rst mid ex_valid", 32'(ex_valid), 32'h0);
        tick();
        rst = 1'b0; #1;
        chk("rst mid cond", 32'(cond), 32'h0);
        chk("rst mid pc_sel", 32'(pc_sel), 32'h5);
        chk("rst mid ex_valid2", 32'(ex_valid), 32'h0);
        $display("txn reset-mid-stall: cond=%0d pc_sel=%0d", cond, pc_sel);

        // mult then mflo with MDU_CYCLES=4
        if_ir = MULT_45; #1;
        chk("mult cond", 32'(cond), 32'h0);
        tick();
        chk("mult ex_ir", ex_ir, MULT_45);
        if_ir = MFLO_6; #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mdu stall %0d", i), 32'(cond), 32'h1);
            tick();
        end
        chk("mdu release cond", 32'(cond), 32'h0);
        tick();
        chk("mflo ex_ir", ex_ir, MFLO_6);
        chk("mflo ex_dest", 32'(ex_dest), 32'h6);
        $display("txn mdu: mflo issued after wait");

        // Interrupt on a jump
        if_ir = J_100; if_pc = 32'h2040; intr_req = 1'b1; #1;
        chk("intr pc_sel", 32'(pc_sel), 32'h2);
        chk("intr epc_wr pre", 32'(epc_wr), 32'h0);
        tick();
        chk("intr epc_wr", 32'(epc_wr), 32'h1);
        chk("intr epc_val", epc_val, 32'h2040);
        chk("intr no issue", 32'(ex_valid), 32'h0);
        if_ir = NOP; if_pc = 32'h0080; #1;
        chk("intr masked pc_sel", 32'(pc_sel), 32'h5);
        tick();
        chk("intr epc_wr drop", 32'(epc_wr), 32'h0);
        intr_req = 1'b0;
        $display("txn interrupt: epc_val=%08h", epc_val);

        // eret
        if_ir = ERET; #1;
        chk("eret pc_sel", 32'(pc_sel), 32'h3);
        tick();
        chk("eret ex_dest", 32'(ex_dest), 32'h0);
        $display("txn eret: pc_sel=3");

        // jal
        if_ir = JAL_100; if_pc = 32'h3000_0010; #1;
        chk("jal pc_sel", 32'(pc_sel), 32'h4);
        chk("jal connect", connect, 32'h3000_0400);
        tick();
        chk("jal ex_dest", 32'(ex_dest), 32'd31);
        chk("jal ex_reg_write", 32'(ex_reg_write), 32'h1);
        $display("txn jal: connect=%08h", connect);

        // jr $31 right behind jal: branch-operand stall, no extra hold
        if_ir = JR_31; #1;
        chk("jr detect cond", 32'(cond), 32'h1);
        tick();
        chk("jr hold1 cond", 32'(cond), 32'h1);
        tick();
        chk("jr resolve cond", 32'(cond), 32'h0);
        chk("jr pc_sel", 32'(pc_sel), 32'h1);
        tick();
        $display("txn jr: pc_sel=1");

        // Immediate extension
        if_ir = ORI_7; #1;
        tick();
        chk("ori imm32", ex_imm32, 32'h0000_8000);
        if_ir = ADDI_7; #1;
        tick();
        chk("addi imm32", ex_imm32, 32'hFFFF_8000);
        $display("txn imm: addi imm32=%08h", ex_imm32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
